// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// The line is oversampled at 16x baud and each character is presented with a one-clock strobe.
module uart_rx #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE     = 19_200,
  parameter int unsigned PARITY        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned DIVISOR  = CLK_FREQUENCY / (BAUD_RATE * 16);
  localparam int unsigned DIV_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned SAMP_W   = 4;
  localparam int unsigned BIT_W    = 3;
  localparam int unsigned DATA_W   = 8;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [SAMP_W-1:0] SAMP_MID = SAMP_W'(7);
  localparam logic [SAMP_W-1:0] SAMP_END = SAMP_W'(15);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic              rx_meta, rx_s;
  logic [DIV_W-1:0]  div_q;
  logic [SAMP_W-1:0] samp_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;

  logic tick_c, samp_mid_c, samp_end_c, par_bad_c;
  logic clr_div_c, clr_samp_c, samp_inc_c, shift_en_c, par_cap_c, done_c;

  // Two-flop synchronizer; the idle line is high so the flops reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Free-running 16x oversample divider, realigned to the falling start edge.
  assign tick_c = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (clr_div_c || tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign samp_mid_c = tick_c && (samp_q == SAMP_MID);
  assign samp_end_c = tick_c && (samp_q == SAMP_END);
  assign par_bad_c  = ((^{shift_q, par_q}) != 1'(PARITY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_div_c  = 1'b0;
    clr_samp_c = 1'b0;
    samp_inc_c = 1'b0;
    shift_en_c = 1'b0;
    par_cap_c  = 1'b0;
    done_c     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d    = S_START;
          clr_div_c  = 1'b1;
          clr_samp_c = 1'b1;
        end
      end
      S_START: begin
        samp_inc_c = tick_c;
        if (samp_mid_c) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_DATA;
            clr_samp_c = 1'b1;
          end
        end
      end
      S_DATA: begin
        samp_inc_c = tick_c;
        if (samp_end_c) begin
          shift_en_c = 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        samp_inc_c = tick_c;
        if (samp_end_c) begin
          par_cap_c = 1'b1;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        samp_inc_c = tick_c;
        if (samp_end_c) begin
          done_c  = 1'b1;
          state_d = rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tick-within-bit and data-bit counters; both wrap naturally at their widths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      bit_q  <= '0;
    end else begin
      if (clr_samp_c) begin
        samp_q <= '0;
      end else if (samp_inc_c) begin
        samp_q <= samp_q + SAMP_W'(1);
      end
      if (clr_samp_c) begin
        bit_q <= '0;
      end else if (shift_en_c) begin
        bit_q <= bit_q + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      if (shift_en_c) begin
        shift_q <= {rx_s, shift_q[DATA_W-1:1]};
      end
      if (par_cap_c) begin
        par_q <= rx_s;
      end
    end
  end

  // Result registers load one clock after the stop sample and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout          <= '0;
      data_strobe   <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_strobe <= done_c;
      busy        <= (state_d != S_IDLE);
      if (done_c) begin
        dout          <= shift_q;
        parity_error  <= par_bad_c;
        framing_error <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames and compares every strobe
// against a frame-level model of data, parity and stop-bit rules.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 12_500;
  localparam int          BIT_T  = 800;   // 80 clocks of 10 time units

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] dout;
  logic       data_strobe;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] q_dout[$];
  logic       q_pe[$];
  logic       q_fe[$];
  int         q_cyc[$];

  uart_rx #(
    .CLK_FREQUENCY(CLK_HZ),
    .BAUD_RATE    (BAUD),
    .PARITY       (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_in        (rx_in),
    .dout         (dout),
    .data_strobe  (data_strobe),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One entry per clock the strobe is seen high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && data_strobe === 1'b1) begin
      q_dout.push_back(dout);
      q_pe.push_back(parity_error);
      q_fe.push_back(framing_error);
      q_cyc.push_back(cyc);
    end
  end

  // Parity bit that makes the total count of ones odd.
  function automatic logic odd_par(input logic [7:0] d);
    return (($countones(d) % 2) == 0);
  endfunction

  function automatic logic model_pe(input logic [7:0] d, input logic p);
    return ((($countones(d) + int'(p)) % 2) != 1);
  endfunction

  task automatic clear_q();
    q_dout.delete();
    q_pe.delete();
    q_fe.delete();
    q_cyc.delete();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int bt);
    rx_in = 1'b0;
    #bt;
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      #bt;
    end
    rx_in = p;
    #bt;
    rx_in = stop;
    #bt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout_in_reset: got %h want 00", dout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_in_reset: got %b want 0", busy); end
    rst_n = 1'b1;
    #(2 * BIT_T);
    @(negedge clk);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
    total++; if (parity_error !== 1'b0) begin bad++; $display("FAIL reset_pe: got %b want 0", parity_error); end
    total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL reset_fe: got %b want 0", framing_error); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (data_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", data_strobe); end
    total++; if (q_dout.size() != 0) begin bad++; $display("FAIL reset_no_strobe: got %0d strobes want 0", q_dout.size()); end
  endtask

  task automatic test_single();
    int t0;
    int lat;
    clear_q();
    @(posedge clk);
    #1;
    t0 = cyc;
    send_frame(8'h55, 1'b1, 1'b1, BIT_T);
    #(BIT_T);
    @(negedge clk);
    total++; if (q_dout.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", q_dout.size()); end
    if (q_dout.size() >= 1) begin
      lat = q_cyc[0] - t0;
      total++; if (q_dout[0] !== 8'h55) begin bad++; $display("FAIL single_dout: got %h want 55", q_dout[0]); end
      total++; if (q_pe[0] !== 1'b0 || q_fe[0] !== 1'b0) begin bad++; $display("FAIL single_flags: got pe=%b fe=%b want 0 0", q_pe[0], q_fe[0]); end
      total++; if (lat < 836 || lat > 850) begin bad++; $display("FAIL single_latency: got %0d clocks want 836..850", lat); end
    end
    total++; if (dout !== 8'h55 || busy !== 1'b0) begin bad++; $display("FAIL single_hold: got dout=%h busy=%b want 55 0", dout, busy); end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [3];
    logic       pars  [3];
    bytes = '{8'h07, 8'hA3, 8'hFF};
    pars  = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      clear_q();
      send_frame(bytes[i], pars[i], 1'b1, BIT_T);
      #(BIT_T);
      @(negedge clk);
      total++; if (q_dout.size() != 1) begin bad++; $display("FAIL parity_count[%0d]: got %0d want 1", i, q_dout.size()); end
      total++; if (dout !== bytes[i]) begin bad++; $display("FAIL parity_dout[%0d]: got %h want %h", i, dout, bytes[i]); end
      total++; if (parity_error !== model_pe(bytes[i], pars[i])) begin bad++; $display("FAIL parity_pe[%0d]: got %b want %b", i, parity_error, model_pe(bytes[i], pars[i])); end
      total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL parity_fe[%0d]: got %b want 0", i, framing_error); end
    end
  endtask

  task automatic test_framing();
    clear_q();
    send_frame(8'h3C, 1'b1, 1'b0, BIT_T);
    #(2 * BIT_T);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy: got %b want 1", busy); end
    total++; if (framing_error !== 1'b1 || dout !== 8'h3C) begin bad++; $display("FAIL break_result: got fe=%b dout=%h want 1 3c", framing_error, dout); end
    total++; if (parity_error !== 1'b0) begin bad++; $display("FAIL break_pe: got %b want 0", parity_error); end
    #(BIT_T);
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_release: got busy=%b want 0", busy); end
    total++; if (q_dout.size() != 1) begin bad++; $display("FAIL break_single_strobe: got %0d want 1", q_dout.size()); end
    #(BIT_T);
    send_frame(8'h81, odd_par(8'h81), 1'b1, BIT_T);
    #(BIT_T);
    @(negedge clk);
    total++; if (q_dout.size() != 2) begin bad++; $display("FAIL after_break_count: got %0d want 2", q_dout.size()); end
    total++; if (dout !== 8'h81 || framing_error !== 1'b0 || parity_error !== 1'b0) begin
      bad++; $display("FAIL after_break: got dout=%h fe=%b pe=%b want 81 0 0", dout, framing_error, parity_error);
    end
  endtask

  task automatic test_glitch();
    clear_q();
    rx_in = 1'b0;
    #200;
    rx_in = 1'b1;
    #(BIT_T);
    @(negedge clk);
    total++; if (q_dout.size() != 0) begin bad++; $display("FAIL glitch_strobe: got %0d want 0", q_dout.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
    total++; if (dout !== 8'h81 || parity_error !== 1'b0 || framing_error !== 1'b0) begin
      bad++; $display("FAIL glitch_hold: got dout=%h pe=%b fe=%b want 81 0 0", dout, parity_error, framing_error);
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'h00, 1'b1, 1'b1, BIT_T);
    send_frame(8'hFF, 1'b1, 1'b1, BIT_T);
    #(BIT_T);
    @(negedge clk);
    total++; if (q_dout.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", q_dout.size()); end
    if (q_dout.size() >= 2) begin
      total++; if (q_dout[0] !== 8'h00 || q_dout[1] !== 8'hFF) begin bad++; $display("FAIL b2b_data: got %h %h want 00 ff", q_dout[0], q_dout[1]); end
      total++; if (q_pe[0] | q_pe[1] | q_fe[0] | q_fe[1]) begin bad++; $display("FAIL b2b_flags: got pe=%b%b fe=%b%b want 0", q_pe[0], q_pe[1], q_fe[0], q_fe[1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'hC4;
    clear_q();
    rx_in = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 3; i++) begin
      rx_in = d[i];
      #(BIT_T);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || data_strobe !== 1'b0) begin bad++; $display("FAIL midreset_async: got busy=%b strobe=%b want 0 0", busy, data_strobe); end
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #(2 * BIT_T);
    @(negedge clk);
    total++; if (q_dout.size() != 0 || dout !== 8'h00) begin bad++; $display("FAIL midreset_discard: got %0d strobes dout=%h want 0 00", q_dout.size(), dout); end
    send_frame(8'h12, odd_par(8'h12), 1'b1, BIT_T);
    #(BIT_T);
    @(negedge clk);
    total++; if (q_dout.size() != 1) begin bad++; $display("FAIL midreset_count: got %0d want 1", q_dout.size()); end
    total++; if (dout !== 8'h12 || parity_error !== 1'b0) begin bad++; $display("FAIL midreset_data: got %h pe=%b want 12 0", dout, parity_error); end
  endtask

  task automatic test_baud_skew();
    int         bts [2];
    logic [7:0] d2;
    bts = '{784, 816};
    for (int k = 0; k < 2; k++) begin
      clear_q();
      d2 = 8'($urandom);
      send_frame(8'h12, odd_par(8'h12), 1'b1, bts[k]);
      send_frame(d2, odd_par(d2), 1'b1, bts[k]);
      #(BIT_T);
      @(negedge clk);
      total++; if (q_dout.size() != 2) begin bad++; $display("FAIL skew_count[%0d]: got %0d want 2", bts[k], q_dout.size()); end
      if (q_dout.size() >= 2) begin
        total++; if (q_dout[0] !== 8'h12 || q_dout[1] !== d2) begin bad++; $display("FAIL skew_data[%0d]: got %h %h want 12 %h", bts[k], q_dout[0], q_dout[1], d2); end
        total++; if (q_pe[0] | q_pe[1] | q_fe[0] | q_fe[1]) begin bad++; $display("FAIL skew_flags[%0d]: got nonzero flags want 0", bts[k]); end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_d[$];
    logic       exp_pe[$];
    logic       exp_fe[$];
    logic [7:0] d;
    logic       p;
    logic       stop;
    clear_q();
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      p    = odd_par(d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      exp_d.push_back(d);
      exp_pe.push_back(model_pe(d, p));
      exp_fe.push_back(!stop);
      send_frame(d, p, stop, BIT_T);
      if (!stop) begin
        #($urandom_range(1, 2) * BIT_T);
        rx_in = 1'b1;
        #(BIT_T);
      end else begin
        #($urandom_range(0, 2) * BIT_T / 2);
      end
    end
    #(BIT_T);
    @(negedge clk);
    total++; if (q_dout.size() != exp_d.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", q_dout.size(), exp_d.size()); end
    if (q_dout.size() == exp_d.size()) begin
      for (int i = 0; i < exp_d.size(); i++) begin
        total++;
        if (q_dout[i] !== exp_d[i] || q_pe[i] !== exp_pe[i] || q_fe[i] !== exp_fe[i]) begin
          bad++;
          $display("FAIL rand_frame[%0d]: got %h pe=%b fe=%b want %h pe=%b fe=%b",
                   i, q_dout[i], q_pe[i], q_fe[i], exp_d[i], exp_pe[i], exp_fe[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_in = 1'b1;
    test_reset();
    test_single();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_baud_skew();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for 8-bit characters with odd parity, 1 start bit and 1 stop bit, LSB first.
- Sits directly downstream of the UART transmitter and consumes its serial output, either in loopback on the board or from the host serial line.
- Oversamples the line at 16x the baud rate, validates start, parity and stop bits, and presents each received byte with a one-cycle strobe.

Parameters:
CLK_FREQUENCY, 100_000_000, system clock frequency in Hz
BAUD_RATE, 19_200, serial bit rate in bits/s
PARITY, 1, 1 = odd parity expected, 0 = even parity expected

Ports:
clk  input  1  system clock
rst_n  input  1  reset: one clock; reset is asynchronous and active-low
rx_in  input  1  asynchronous serial line, idle high
dout  output  8  last received data byte
data_strobe  output  1  one-cycle pulse, dout/error flags valid
parity_error  output  1  parity mismatch on last character
framing_error  output  1  stop bit sampled low on last character
busy  output  1  high while a character is being received

Behaviour:
- Reset (rst_n low, asynchronous):
  - dout = 8'h00; data_strobe, parity_error, framing_error, busy = 0.
  - Synchronizer flops = 1; state = IDLE; all counters = 0.
- Input sync: rx_in passes through two flops (rx_s) before any use. All timing below is relative to rx_s.
- Oversample tick:
  - Free-running counter, DIVISOR = CLK_FREQUENCY/(BAUD_RATE*16), integer truncation (100 MHz/19200 gives 325).
  - Tick pulses one clk when the counter reaches DIVISOR-1, then the counter wraps to 0.
  - The counter is cleared on entry to START so that mid-bit sampling is aligned to the falling edge.
- Sample counter (4-bit) counts ticks within a bit; bit counter (3-bit) counts data bits.
- FSM:
  - IDLE: busy = 0. rx_s == 0 -> START, clear tick and sample counters.
  - START: on the 8th tick (mid start bit), sample rx_s.
    - 1 -> false start, return to IDLE with no strobe and no flag change.
    - 0 -> DATA, sample counter = 0.
  - DATA: every 16 ticks sample rx_s into a shift register, LSB first. After bit 7 -> PARITY.
  - PARITY: after 16 ticks, sample the parity bit.
    - Error when ^{data, parity_bit} != PARITY.
    - With PARITY = 1, the total number of ones in data plus parity must be odd.
  - STOP: after 16 ticks, sample the stop bit.
    - Next clk: dout <= shift register; parity_error and framing_error updated; data_strobe = 1 for exactly one clk.
    - Stop = 1 -> IDLE. Stop = 0 -> framing_error = 1, go to BREAK.
  - BREAK: wait until rx_s == 1, then IDLE. No new start is detected while the line stays low.
- busy = 1 in START, DATA, PARITY, STOP and BREAK.
- dout and the error flags hold their values until the next strobe. Both flags update on every strobe; they are not sticky.
- Back-to-back characters:
  - A start edge arriving immediately after a stop sample is accepted, because IDLE is entered right after the stop sample.
  - Tolerates at least ±2% baud mismatch.
- Glitch on the idle line shorter than half a bit -> rejected as a false start.
- Reset mid-character -> immediate return to IDLE; the partial byte is discarded and no strobe is issued.

Test Plan:
- Reset, line idle high for 2 bit times -> all outputs 0, busy = 0, no strobe.
- Send 0x55 with parity 1, stop 1 -> exactly one strobe ~10.5 bit times after the start edge; dout = 8'h55, parity_error = 0, framing_error = 0.
- Send 0x07 with parity 0 -> dout = 8'h07, no errors. Then send 0xA3 with parity 0 (wrong) -> dout = 8'hA3, parity_error = 1. Then send 0xFF with parity 1 -> parity_error clears to 0.
- Send 0x3C with stop bit 0, hold the line low for 3 bit times -> strobe, framing_error = 1, busy stays 1 until the line goes high. No second strobe. The next valid 0x81 (parity 1) is received correctly.
- Pulse the line low for 4 ticks only -> no strobe, busy returns to 0. Send 0x00 (parity 1) back-to-back with 0xFF (parity 1) and no idle gap -> two strobes, dout = 8'h00 then 8'hFF.
- Assert rst_n low mid-DATA of 0xC4, release, then send 0x12 (parity 1) -> no strobe for 0xC4; one strobe with dout = 8'h12. Repeat with baud ±2% -> correct reception.
